// File: rtl/qc_pkg.sv
// ---------------------------------------------------------------------------
// qc_pkg
// Shared widths, instruction layout and dispatcher state encoding for the
// quantum-control instruction dispatch path.
//
// Contents:
//   calc* functions  - derive field widths from the system parameters
//   QW, FID_W, ...   - widths for the default 64 FPGA x 64 qubit system
//   instr_t          - packed view of one issued instruction word
//   disp_state_e     - dispatcher FSM states
// ---------------------------------------------------------------------------
package qc_pkg;

    // Width of a global qubit number
    function automatic int calcQw(input int numFpga, input int numQubitPerFpga);
        return $clog2(numFpga * numQubitPerFpga);
    endfunction

    // Width of the full instruction word: three qubit fields, 18-bit
    // immediate and 4-bit opcode
    function automatic int calcInstrW(input int qw);
        return 3 * qw + 22;
    endfunction

    // Number of link beats needed to carry one instruction word
    function automatic int calcBeats(input int instrW, input int linkW);
        return (instrW + linkW - 1) / linkW;
    endfunction

    localparam int NUM_FPGA_DEF   = 64;
    localparam int NUM_QUBIT_DEF  = 64;
    localparam int NUM_INSTRS_DEF = 100;
    localparam int LINK_W_DEF     = 16;

    localparam int QW      = calcQw(NUM_FPGA_DEF, NUM_QUBIT_DEF);
    localparam int FID_W   = $clog2(NUM_FPGA_DEF);
    localparam int IDX_W   = $clog2(NUM_INSTRS_DEF);
    localparam int INSTR_W = calcInstrW(QW);
    localparam int NBEATS  = calcBeats(INSTR_W, LINK_W_DEF);

    // The destination FPGA is the top FID_W bits of qa
    typedef struct packed {
        logic [QW-1:0] qa;
        logic [QW-1:0] qb;
        logic [QW-1:0] qc;
        logic [17:0]   imm;
        logic [3:0]    opcode;
    } instr_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_RETIRE   = 2'd3
    } disp_state_e;

endpackage

// File: rtl/qc_sync_fifo.sv
// ---------------------------------------------------------------------------
// qc_sync_fifo
// Single-clock FIFO buffering issued {index, instruction} entries between
// the scheduler handshake and the dispatcher FSM.
//
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   push_i       - write push_data_i this cycle
//   push_data_i  - entry to store
//   pop_i        - discard the head entry this cycle
//   pop_data_o   - current head entry (valid while empty_o is low)
//   full_o       - all DEPTH slots occupied
//   empty_o      - no entry stored
//
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// ---------------------------------------------------------------------------
module qc_sync_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic             doPush;
    logic             doPop;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign doPop      = pop_i && !empty_o;
    // A simultaneous pop frees the head slot, so a push is allowed when full
    assign doPush     = push_i && (!full_o || doPop);
    assign pop_data_o = mem_q[rdPtr_q];

    // Storage array needs no reset; the count alone decides what is valid
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= push_data_i;
        end
    end

    // Pointers wrap naturally at DEPTH; the count tracks occupancy so full
    // and empty never need pointer comparisons
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/qc_instr_dispatcher.sv
// ---------------------------------------------------------------------------
// qc_instr_dispatcher
// Retiring end of the scheduler issue interface. Buffers issued instructions,
// sends each one LSB-first in LINK_W-bit beats to the FPGA selected by the
// top bits of qubit A, waits for that FPGA's acknowledge (or a timeout) and
// reports a one-cycle completion carrying the instruction-register index.
//
// Ports:
//   clk, rst                - clock and synchronous active-high reset
//   iss_valid/iss_ready     - issue handshake from the scheduler
//   iss_instr, iss_index    - issued word and its instruction-register index
//   lnk_valid/lnk_ready     - beat handshake towards the control FPGAs
//   lnk_fpga, lnk_data      - destination FPGA and beat payload
//   lnk_last                - marks the final beat of an instruction
//   lnk_ack                 - acknowledge pulse from the destination FPGA
//   done_valid              - one-cycle completion pulse
//   done_index, done_err    - retired index and timeout flag
//   busy                    - work buffered or in flight
// ---------------------------------------------------------------------------
module qc_instr_dispatcher
    import qc_pkg::*;
#(
    parameter int NUM_FPGA           = 64,
    parameter int NUM_QUBIT_PER_FPGA = 64,
    parameter int NUM_INSTRS         = 100,
    parameter int FIFO_DEPTH         = 4,
    parameter int LINK_W             = 16,
    parameter int ACK_TIMEOUT        = 1024,
    localparam int DEST_W  = $clog2(NUM_FPGA),
    localparam int QUBIT_W = calcQw(NUM_FPGA, NUM_QUBIT_PER_FPGA),
    localparam int INDEX_W = $clog2(NUM_INSTRS),
    localparam int WORD_W  = calcInstrW(QUBIT_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               iss_valid,
    output logic               iss_ready,
    input  logic [WORD_W-1:0]  iss_instr,
    input  logic [INDEX_W-1:0] iss_index,
    output logic               lnk_valid,
    input  logic               lnk_ready,
    output logic [DEST_W-1:0]  lnk_fpga,
    output logic [LINK_W-1:0]  lnk_data,
    output logic               lnk_last,
    input  logic               lnk_ack,
    output logic               done_valid,
    output logic [INDEX_W-1:0] done_index,
    output logic               done_err,
    output logic               busy
);

    localparam int BEATS  = calcBeats(WORD_W, LINK_W);
    localparam int PAD_W  = BEATS * LINK_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TMO_W  = $clog2(ACK_TIMEOUT + 1);
    localparam int FIFO_W = INDEX_W + WORD_W;

    logic               fifoPush;
    logic               fifoPop;
    logic               fifoFull;
    logic               fifoEmpty;
    logic [FIFO_W-1:0]  fifoRdData;
    logic [INDEX_W-1:0] popIndex;
    logic [WORD_W-1:0]  popWord;
    logic [PAD_W-1:0]   popPadded;
    logic [DEST_W-1:0]  popDest;

    disp_state_e        state_q;
    logic [PAD_W-1:0]   shift_q;
    logic [INDEX_W-1:0] index_q;
    logic [BEAT_W-1:0]  beat_q;
    logic [TMO_W-1:0]   tmo_q;
    logic               lnkValid_q;
    logic [DEST_W-1:0]  lnkFpga_q;
    logic [LINK_W-1:0]  lnkData_q;
    logic               lnkLast_q;
    logic               doneValid_q;
    logic [INDEX_W-1:0] doneIndex_q;
    logic               doneErr_q;

    // Ready depends only on registered FIFO occupancy, and is held low while
    // reset is asserted so nothing is accepted into a FIFO being cleared
    assign iss_ready = !rst && !fifoFull;
    assign fifoPush  = iss_valid && iss_ready;
    assign fifoPop   = (state_q == ST_IDLE) && !fifoEmpty;

    qc_sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifoPush),
        .push_data_i ({iss_index, iss_instr}),
        .pop_i       (fifoPop),
        .pop_data_o  (fifoRdData),
        .full_o      (fifoFull),
        .empty_o     (fifoEmpty)
    );

    // Head-of-FIFO decode: the word is zero-extended to a whole number of
    // beats and the destination is the top DEST_W bits of qubit A
    assign {popIndex, popWord} = fifoRdData;
    assign popPadded           = PAD_W'(popWord);
    assign popDest             = popWord[WORD_W-1 -: DEST_W];

    // Dispatcher FSM. All link and completion outputs are registered here.
    // The holding register shifts right one beat per accepted beat, so the
    // next payload is always in its low LINK_W bits; the offered beat sits
    // in lnkData_q untouched until lnk_ready takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            index_q     <= '0;
            beat_q      <= '0;
            tmo_q       <= '0;
            lnkValid_q  <= 1'b0;
            lnkFpga_q   <= '0;
            lnkData_q   <= '0;
            lnkLast_q   <= 1'b0;
            doneValid_q <= 1'b0;
            doneIndex_q <= '0;
            doneErr_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifoEmpty) begin
                        state_q    <= ST_SEND;
                        index_q    <= popIndex;
                        beat_q     <= '0;
                        shift_q    <= popPadded >> LINK_W;
                        lnkValid_q <= 1'b1;
                        lnkFpga_q  <= popDest;
                        lnkData_q  <= popPadded[LINK_W-1:0];
                        lnkLast_q  <= (BEATS == 1);
                    end
                end
                ST_SEND: begin
                    if (lnk_ready) begin
                        if (beat_q == BEAT_W'(BEATS - 1)) begin
                            state_q    <= ST_WAIT_ACK;
                            tmo_q      <= '0;
                            lnkValid_q <= 1'b0;
                            lnkFpga_q  <= '0;
                            lnkData_q  <= '0;
                            lnkLast_q  <= 1'b0;
                        end else begin
                            beat_q    <= beat_q + 1'b1;
                            lnkData_q <= shift_q[LINK_W-1:0];
                            shift_q   <= shift_q >> LINK_W;
                            lnkLast_q <= (beat_q == BEAT_W'(BEATS - 2));
                        end
                    end
                end
                ST_WAIT_ACK: begin
                    // Ack is tested first so it wins over a same-cycle timeout
                    if (lnk_ack) begin
                        state_q     <= ST_RETIRE;
                        doneValid_q <= 1'b1;
                        doneIndex_q <= index_q;
                        doneErr_q   <= 1'b0;
                    end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
                        state_q     <= ST_RETIRE;
                        doneValid_q <= 1'b1;
                        doneIndex_q <= index_q;
                        doneErr_q   <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                ST_RETIRE: begin
                    state_q     <= ST_IDLE;
                    doneValid_q <= 1'b0;
                    doneIndex_q <= '0;
                    doneErr_q   <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign lnk_valid  = lnkValid_q;
    assign lnk_fpga   = lnkFpga_q;
    assign lnk_data   = lnkData_q;
    assign lnk_last   = lnkLast_q;
    assign done_valid = doneValid_q;
    assign done_index = doneIndex_q;
    assign done_err   = doneErr_q;
    assign busy       = !fifoEmpty || (state_q != ST_IDLE);

endmodule
